// File: rtl/decimating_accumulator_pkg.sv
// decimating_accumulator_pkg: shared DSP pipeline types and helpers.
package decimating_accumulator_pkg;

    typedef enum logic [1:0] {
        STG_IDLE,
        STG_RUN,
        STG_FLUSH
    } stage_state_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DUMP
    } dec_state_t;

    localparam int MAX_DECIM_LOG2 = 8;

    // A zero-bit counter is not legal, so N=1 still gets a 1-bit counter.
    function automatic int cnt_width(input int log2);
        return (log2 > 0) ? log2 : 1;
    endfunction

endpackage

// File: rtl/decimating_accumulator_sat_add.sv
// sat_add: unsigned adder that clamps to all-ones and flags saturation.
module sat_add #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             sat
);

    logic [WIDTH:0] full;

    assign full = {1'b0, a} + {1'b0, b};
    assign sat  = full[WIDTH];
    assign sum  = sat ? '1 : full[WIDTH-1:0];

endmodule

// File: rtl/decimating_accumulator.sv
// decimating_accumulator: sums blocks of 2**DECIM_LOG2 samples and emits sum and average.
module decimating_accumulator
    import decimating_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DECIM_LOG2 = 2,
    parameter int ACC_WIDTH  = 34
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    input  logic                  enable,
    input  logic                  clear,
    output logic [ACC_WIDTH-1:0]  sum_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  overflow,
    output logic [15:0]           block_count
);

    localparam int CW = cnt_width(DECIM_LOG2);
    localparam logic [CW-1:0] LAST = CW'((1 << DECIM_LOG2) - 1);

    dec_state_t           state;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] add_sum;
    logic                 add_sat;
    logic [CW-1:0]        count;
    logic                 accept;
    logic                 is_last;

    assign accept  = valid_in && enable && !clear;
    assign is_last = count == LAST;

    sat_add #(
        .WIDTH(ACC_WIDTH)
    ) u_sat_add (
        .a  (acc),
        .b  (ACC_WIDTH'(data_in)),
        .sum(add_sum),
        .sat(add_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            count       <= '0;
            sum_out     <= '0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            overflow    <= 1'b0;
            block_count <= '0;
        end else if (clear) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            overflow  <= overflow | add_sat;
            valid_out <= is_last;
            if (is_last) begin
                state       <= DUMP;
                acc         <= '0;
                count       <= '0;
                sum_out     <= add_sum;
                data_out    <= DATA_WIDTH'(add_sum >> DECIM_LOG2);
                block_count <= block_count + 16'd1;
            end else begin
                state <= ACCUM;
                acc   <= add_sum;
                count <= count + 1'b1;
            end
        end else begin
            // Idle or stalled by enable: a partial block is held as-is.
            valid_out <= 1'b0;
            if (state == DUMP)
                state <= IDLE;
        end
    end

endmodule

// File: tb/tb_decimating_accumulator.sv
// tb_decimating_accumulator: directed scoreboard bench for decimating_accumulator.
module tb_decimating_accumulator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [31:0] din0, dout0;
    logic        v0i, en0, clr0, vo0, ov0;
    logic [33:0] sum0;
    logic [15:0] bc0;

    logic [7:0]  din1, dout1;
    logic        v1i, en1, clr1, vo1, ov1;
    logic [8:0]  sum1;
    logic [15:0] bc1;

    decimating_accumulator u_d0 (
        .clk(clk), .rst_n(rst_n), .data_in(din0), .valid_in(v0i), .enable(en0),
        .clear(clr0), .sum_out(sum0), .data_out(dout0), .valid_out(vo0),
        .overflow(ov0), .block_count(bc0)
    );

    decimating_accumulator #(.DATA_WIDTH(8), .DECIM_LOG2(2), .ACC_WIDTH(9)) u_d1 (
        .clk(clk), .rst_n(rst_n), .data_in(din1), .valid_in(v1i), .enable(en1),
        .clear(clr1), .sum_out(sum1), .data_out(dout1), .valid_out(vo1),
        .overflow(ov1), .block_count(bc1)
    );

    typedef struct {
        logic [63:0] s;
        logic [63:0] d;
        logic [63:0] b;
        int          c;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (vo0) begin
            if (q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL d0_unexpected_pulse: got sum %0d at cycle %0d want no pulse", sum0, cyc);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("d0_sum", 64'(sum0), e.s);
                chk("d0_data", 64'(dout0), e.d);
                chk("d0_count", 64'(bc0), e.b);
                chk("d0_cycle", 64'(cyc), 64'(e.c));
            end
        end
    end

    always @(negedge clk) begin
        if (vo1) begin
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL d1_unexpected_pulse: got sum %0d at cycle %0d want no pulse", sum1, cyc);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("d1_sum", 64'(sum1), e.s);
                chk("d1_data", 64'(dout1), e.d);
                chk("d1_count", 64'(bc1), e.b);
                chk("d1_cycle", 64'(cyc), 64'(e.c));
            end
        end
    end

    task automatic step0(input logic [31:0] d, input logic v, input logic e, input logic c);
        din0 = d; v0i = v; en0 = e; clr0 = c;
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input logic [7:0] d, input logic v, input logic e, input logic c);
        din1 = d; v1i = v; en1 = e; clr1 = c;
        @(posedge clk);
        #1;
    endtask

    task automatic exp0(input logic [63:0] s, input logic [63:0] d, input logic [63:0] b);
        q0.push_back('{s: s, d: d, b: b, c: cyc});
    endtask

    task automatic exp1(input logic [63:0] s, input logic [63:0] d, input logic [63:0] b);
        q1.push_back('{s: s, d: d, b: b, c: cyc});
    endtask

    initial begin
        din0 = '0; v0i = 0; en0 = 0; clr0 = 0;
        din1 = '0; v1i = 0; en1 = 0; clr1 = 0;
        #12;
        chk("rst_sum", 64'(sum0), 0);
        chk("rst_data", 64'(dout0), 0);
        chk("rst_valid", 64'(vo0), 0);
        chk("rst_ovf", 64'(ov0), 0);
        chk("rst_count", 64'(bc0), 0);
        chk("rst_d1_sum", 64'(sum1), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step0(0, 0, 1, 0);

        // saturation on the narrow instance
        for (int i = 0; i < 4; i++) step1(8'd255, 1, 1, 0);
        exp1(511, 127, 1);
        step1(0, 0, 1, 0);
        chk("d1_ovf_set", 64'(ov1), 1);
        for (int i = 0; i < 4; i++) step1(8'd1, 1, 1, 0);
        exp1(4, 1, 2);
        step1(0, 0, 1, 0);
        chk("d1_ovf_held", 64'(ov1), 1);
        step1(0, 0, 1, 1);
        chk("d1_ovf_cleared", 64'(ov1), 0);
        chk("d1_sum_after_clear", 64'(sum1), 4);
        step1(0, 0, 1, 0);

        // 1,2,3,4
        for (int i = 1; i <= 4; i++) step0(32'(i), 1, 1, 0);
        exp0(10, 2, 1);
        step0(0, 0, 1, 0);
        chk("valid_drop", 64'(vo0), 0);
        chk("sum_hold", 64'(sum0), 10);

        // 8 contiguous samples of 100
        for (int i = 0; i < 8; i++) begin
            step0(100, 1, 1, 0);
            if (i == 3) exp0(400, 100, 2);
            if (i == 7) exp0(400, 100, 3);
        end
        step0(0, 0, 1, 0);

        // enable gap mid-block
        step0(5, 1, 1, 0);
        step0(5, 1, 1, 0);
        for (int i = 0; i < 3; i++) step0(5, 1, 0, 0);
        step0(5, 1, 1, 0);
        step0(5, 1, 1, 0);
        exp0(20, 5, 4);
        step0(0, 0, 1, 0);

        // clear beats valid_in
        step0(7, 1, 1, 0);
        step0(7, 1, 1, 0);
        step0(7, 1, 1, 1);
        chk("clear_keeps_sum", 64'(sum0), 20);
        chk("clear_keeps_count", 64'(bc0), 4);
        for (int i = 0; i < 4; i++) step0(1, 1, 1, 0);
        exp0(4, 1, 5);
        step0(0, 0, 1, 0);
        chk("clear_ovf", 64'(ov0), 0);

        // asynchronous reset mid-block
        step0(3, 1, 1, 0);
        step0(3, 1, 1, 0);
        v0i = 0;
        rst_n = 1'b0;
        #1;
        chk("midrst_sum", 64'(sum0), 0);
        chk("midrst_data", 64'(dout0), 0);
        chk("midrst_valid", 64'(vo0), 0);
        chk("midrst_count", 64'(bc0), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step0(3, 1, 1, 0);
        exp0(12, 3, 1);
        for (int i = 0; i < 3; i++) step0(0, 0, 1, 0);

        chk("d0_pending", 64'(q0.size()), 0);
        chk("d1_pending", 64'(q1.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decimating_accumulator.md
DECIMATING_ACCUMULATOR -- requirements
Module: decimating_accumulator

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, which sets the sample width of data_in and data_out.
REQ-002 The block SHALL have parameter DECIM_LOG2, default 2, where the decimation factor is N = 2**DECIM_LOG2 and the legal range is 0..8.
REQ-003 The block SHALL have parameter ACC_WIDTH, default 34, which sets the accumulator width and SHALL satisfy ACC_WIDTH >= DATA_WIDTH.
REQ-004 The block SHALL have port clk, input, 1 bit: the clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port data_in, input, DATA_WIDTH bits: unsigned sample from the upstream processing stage.
REQ-007 The block SHALL have port valid_in, input, 1 bit: data_in is valid this cycle; there is no backpressure.
REQ-008 The block SHALL have port enable, input, 1 bit: when low, input samples are ignored.
REQ-009 The block SHALL have port clear, input, 1 bit: synchronous clear of the accumulation and of overflow.
REQ-010 The block SHALL have port sum_out, output, ACC_WIDTH bits: the block sum of N samples.
REQ-011 The block SHALL have port data_out, output, DATA_WIDTH bits: the block average, sum_out >> DECIM_LOG2, truncated.
REQ-012 The block SHALL have port valid_out, output, 1 bit: a one-cycle pulse marking sum_out and data_out valid.
REQ-013 The block SHALL have port overflow, output, 1 bit: sticky flag set when accumulator saturation has occurred.
REQ-014 The block SHALL have port block_count, output, 16 bits: the number of emitted outputs, wrapping modulo 2**16.

Function
REQ-015 A sample SHALL be accepted iff valid_in && enable && !clear at a rising edge.
REQ-016 Each accepted sample SHALL be added to acc using a saturating add: if the true sum > 2**ACC_WIDTH-1, acc = 2**ACC_WIDTH-1 and overflow is set.
REQ-017 On acceptance of the Nth sample of a block, the block SHALL, on the next cycle:
- drive valid_out=1;
- drive sum_out = the final acc value;
- drive data_out = that value >> DECIM_LOG2;
- increment block_count.
REQ-018 The latency from the Nth accepted sample to valid_out SHALL be exactly 1 cycle.
REQ-019 valid_out SHALL otherwise be 0.
REQ-020 sum_out and data_out SHALL hold their last value between pulses.
REQ-021 On acceptance of the Nth sample, acc and the sample counter SHALL restart from 0.
REQ-022 A sample accepted in the same cycle as valid_out=1 SHALL be the first sample of the next block, with no lost samples.
REQ-023 The FSM SHALL have states IDLE (no partial block), ACCUM (1..N-1 samples held) and DUMP (valid_out cycle).
REQ-024 FSM transitions SHALL be:
- IDLE -> ACCUM on acceptance;
- IDLE -> DUMP on acceptance when N=1;
- ACCUM -> DUMP on the Nth acceptance;
- DUMP -> ACCUM on acceptance, or DUMP when N=1;
- DUMP -> IDLE when no sample is accepted.
REQ-025 enable low mid-block SHALL hold acc, the counter and the state unchanged; the block resumes when enable returns.
REQ-026 clear SHALL have priority over valid_in: the next cycle has acc=0, count=0, state IDLE, valid_out=0 and overflow=0.
REQ-027 clear SHALL leave sum_out, data_out and block_count unchanged.
REQ-028 Once set, overflow SHALL remain 1 until clear or reset.
REQ-029 When overflow and an accepted sample occur in the same cycle, overflow SHALL be set and the saturated value used.
REQ-030 data_out SHALL be the low DATA_WIDTH bits of the shifted sum.

Reset
REQ-031 On rst_n low, the block SHALL asynchronously set:
- sum_out=0, data_out=0, valid_out=0, overflow=0, block_count=0;
- acc=0, counter=0, state=IDLE.
REQ-032 Reset asserted mid-block SHALL discard the partial sum; the first sample accepted after release starts a new block.
REQ-033 Outputs SHALL be stable at reset values from assertion until the first rising clk after release.

Structure
REQ-034 The state enum (IDLE/ACCUM/DUMP) SHALL be defined in the shared DSP pipeline package, beside the existing stage state typedefs.
REQ-035 The saturating adder SHALL be a sub-module sat_add, parameterised by width, with outputs sum and sat.
REQ-036 The sample counter SHALL be DECIM_LOG2 bits wide, or 1 bit minimum.

Verification
REQ-037 The bench SHALL cover the following directed scenarios:
- Defaults, samples 1,2,3,4 back-to-back -> 1 cycle after the 4th: valid_out=1, sum_out=10, data_out=2, block_count=1.
- 8 contiguous samples of 100 -> two pulses 4 cycles apart, each sum_out=400 and data_out=100, no gap or sample loss.
- Samples 5,5, enable low for 3 cycles with valid_in=1, then samples 5,5 -> a single pulse with sum_out=20.
- DATA_WIDTH=8, ACC_WIDTH=9, samples 255 x4 -> sum_out=511, data_out=127, overflow=1, held through the next block until clear.
- Samples 7,7, then clear together with valid_in, then samples 1,1,1,1 -> sum_out=4, overflow=0.
- rst_n pulsed low mid-block after 2 samples -> all outputs 0; 4 new samples of 3 -> sum_out=12, block_count=1.
